// File: rtl/md5_top_axi4_lite.sv
// md5_top_axi4_lite: AXI4-Lite MD5 compression peripheral, one round per clock.
// Optional MD5_BLOCK_COUNT_EN adds a completed-block counter at 0x60.
module md5_top_axi4_lite #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] i_axi_awaddr,
  input  logic [3:0]    i_axi_awcache,
  input  logic [2:0]    i_axi_awprot,
  input  logic          i_axi_awvalid,
  output logic          o_axi_awready,
  input  logic [DW-1:0] i_axi_wdata,
  input  logic [DW/8-1:0] i_axi_wstrb,
  input  logic          i_axi_wvalid,
  output logic          o_axi_wready,
  output logic [1:0]    o_axi_bresp,
  output logic          o_axi_bvalid,
  input  logic          i_axi_bready,
  input  logic [AW-1:0] i_axi_araddr,
  input  logic [3:0]    i_axi_arcache,
  input  logic [2:0]    i_axi_arprot,
  input  logic          i_axi_arvalid,
  output logic          o_axi_arready,
  output logic [DW-1:0] o_axi_rdata,
  output logic [1:0]    o_axi_rresp,
  output logic          o_axi_rvalid,
  input  logic          i_axi_rready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [31:0] IV [4] = '{
    32'h67452301, 32'hefcdab89,
    32'h98badcfe, 32'h10325476
  };

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  logic [1:0]  st;
  logic [6:0]  cnt;
  logic [31:0] msg [16];
  logic [31:0] h [4];
  logic [31:0] va, vb, vc, vd;
  logic        hash_valid;
  logic        ready;
  logic        bvalid, rvalid;
  logic [31:0] rdata, rd_mux;

  logic        wr_hs, rd_hs;
  logic [5:0]  wa, ra;
  logic [3:0]  wa_msg, ra_msg;
  logic        wr_ctrl, wr_rst, wr_msg, start;
  logic        unused;

  assign unused = ^{i_axi_awcache, i_axi_awprot,
                    i_axi_arcache, i_axi_arprot,
                    i_axi_awaddr[AW-1:8], i_axi_awaddr[1:0],
                    i_axi_araddr[AW-1:8], i_axi_araddr[1:0]};

  assign ready = (st == ST_IDLE);

  assign wr_hs = rst_ni & i_axi_awvalid & i_axi_wvalid & ~bvalid;
  assign rd_hs = rst_ni & i_axi_arvalid & ~rvalid;

  assign o_axi_awready = wr_hs;
  assign o_axi_wready  = wr_hs;
  assign o_axi_arready = rst_ni & ~rvalid;
  assign o_axi_bvalid  = bvalid;
  assign o_axi_bresp   = 2'b00;
  assign o_axi_rvalid  = rvalid;
  assign o_axi_rresp   = 2'b00;
  assign o_axi_rdata   = rdata;

  assign wa     = i_axi_awaddr[7:2];
  assign ra     = i_axi_araddr[7:2];
  assign wa_msg = 4'(wa[3:0] - 4'd4);
  assign ra_msg = 4'(ra[3:0] - 4'd4);

  assign wr_ctrl = wr_hs & (wa == 6'd1) & i_axi_wstrb[0] & i_axi_wdata[0];
  assign wr_rst  = wr_hs & (wa == 6'd2) & i_axi_wstrb[0] & i_axi_wdata[0];
  assign wr_msg  = wr_hs & (wa >= 6'd4) & (wa <= 6'd19) & ready;
  assign start   = wr_ctrl & ready;

  // Round datapath: boolean function, message schedule and shift
  logic [5:0]  r;
  logic [31:0] f, sum, rot;
  logic [3:0]  g;
  logic [4:0]  s;

  assign r = cnt[5:0];

  always_comb begin
    f = 32'h0;
    g = 4'h0;
    unique case (r[5:4])
      2'd0: begin
        f = (vb & vc) | (~vb & vd);
        g = r[3:0];
      end
      2'd1: begin
        f = (vd & vb) | (~vd & vc);
        g = 4'(4'd5 * r[3:0] + 4'd1);
      end
      2'd2: begin
        f = vb ^ vc ^ vd;
        g = 4'(4'd3 * r[3:0] + 4'd5);
      end
      default: begin
        f = vc ^ (vb | ~vd);
        g = 4'(4'd7 * r[3:0]);
      end
    endcase
  end

  always_comb begin
    s = 5'd0;
    unique case ({r[5:4], r[1:0]})
      4'h0: s = 5'd7;
      4'h1: s = 5'd12;
      4'h2: s = 5'd17;
      4'h3: s = 5'd22;
      4'h4: s = 5'd5;
      4'h5: s = 5'd9;
      4'h6: s = 5'd14;
      4'h7: s = 5'd20;
      4'h8: s = 5'd4;
      4'h9: s = 5'd11;
      4'ha: s = 5'd16;
      4'hb: s = 5'd23;
      4'hc: s = 5'd6;
      4'hd: s = 5'd10;
      4'he: s = 5'd15;
      default: s = 5'd21;
    endcase
  end

  assign sum = f + va + K_TAB[r] + msg[g];
  assign rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));

  // cnt==64 marks the feed-forward cycle after the last round
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st         <= ST_IDLE;
      cnt        <= 7'd0;
      va         <= 32'h0;
      vb         <= 32'h0;
      vc         <= 32'h0;
      vd         <= 32'h0;
      h          <= IV;
      hash_valid <= 1'b0;
    end else if (wr_rst) begin
      st         <= ST_IDLE;
      cnt        <= 7'd0;
      h          <= IV;
      hash_valid <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (start) st <= ST_LOAD;
        end
        ST_LOAD: begin
          va         <= h[0];
          vb         <= h[1];
          vc         <= h[2];
          vd         <= h[3];
          cnt        <= 7'd0;
          hash_valid <= 1'b0;
          st         <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt[6]) begin
            h[0]       <= h[0] + va;
            h[1]       <= h[1] + vb;
            h[2]       <= h[2] + vc;
            h[3]       <= h[3] + vd;
            hash_valid <= 1'b1;
            st         <= ST_IDLE;
          end else begin
            va  <= vd;
            vd  <= vc;
            vc  <= vb;
            vb  <= vb + rot;
            cnt <= cnt + 7'd1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) msg[i] <= 32'h0;
    end else if (wr_msg) begin
      for (int b = 0; b < 4; b++)
        if (i_axi_wstrb[b])
          msg[wa_msg][8*b +: 8] <= i_axi_wdata[8*b +: 8];
    end
  end

`ifdef MD5_BLOCK_COUNT_EN
  logic [31:0] blk_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || wr_rst) begin
      blk_cnt <= 32'h0;
    end else if (st == ST_RUN && cnt[6]) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = 32'h0;
    unique case (1'b1)
      (ra == 6'd0):
        rd_mux = {30'h0, hash_valid, ready};
      (ra >= 6'd4 && ra <= 6'd19):
        rd_mux = msg[ra_msg];
      (ra >= 6'd20 && ra <= 6'd23):
        rd_mux = h[ra[1:0]];
`ifdef MD5_BLOCK_COUNT_EN
      (ra == 6'd24):
        rd_mux = blk_cnt;
`endif
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bvalid <= 1'b0;
    end else if (wr_hs) begin
      bvalid <= 1'b1;
    end else if (i_axi_bready) begin
      bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid <= 1'b0;
      rdata  <= 32'h0;
    end else if (rd_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_mux;
    end else if (i_axi_rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_md5_top_axi4_lite.sv
// tb_md5_top_axi4_lite: known digests, random blocks against a loop-level
// MD5 model, and handshake/busy/reset corner sequences.
module tb_md5_top_axi4_lite;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  md5_top_axi4_lite dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_axi_awaddr(awaddr), .i_axi_awcache(4'h0),
    .i_axi_awprot(3'h0), .i_axi_awvalid(awvalid),
    .o_axi_awready(awready), .i_axi_wdata(wdata),
    .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid),
    .o_axi_wready(wready), .o_axi_bresp(bresp),
    .o_axi_bvalid(bvalid), .i_axi_bready(bready),
    .i_axi_araddr(araddr), .i_axi_arcache(4'h0),
    .i_axi_arprot(3'h0), .i_axi_arvalid(arvalid),
    .o_axi_arready(arready), .o_axi_rdata(rdata),
    .o_axi_rresp(rresp), .o_axi_rvalid(rvalid),
    .i_axi_rready(rready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference model: RFC 1321 block compression written as a plain loop
  logic [31:0] ks [64];
  int          sh [64];
  logic [31:0] ref_h [4];
  logic [31:0] cur_msg [16];
  logic [31:0] words [$];

  function automatic void init_tables();
    int sg [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                      '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    for (int i = 0; i < 64; i++) begin
      real x;
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      ks[i] = 32'(longint'($floor(4294967296.0 * x)));
      sh[i] = sg[i / 16][i % 4];
    end
  endfunction

  function automatic void ref_iv();
    ref_h[0] = 32'h67452301; ref_h[1] = 32'hefcdab89;
    ref_h[2] = 32'h98badcfe; ref_h[3] = 32'h10325476;
  endfunction

  function automatic void md5_ref();
    logic [31:0] a, b, c, d, f, t;
    int g;
    a = ref_h[0]; b = ref_h[1]; c = ref_h[2]; d = ref_h[3];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d; g = (3*i + 5) % 16; end
      else begin f = c ^ (b | ~d); g = (7*i) % 16; end
      t = f + a + ks[i] + cur_msg[g];
      a = d; d = c; c = b;
      b = b + ((t << sh[i]) | (t >> (32 - sh[i])));
    end
    ref_h[0] += a; ref_h[1] += b; ref_h[2] += c; ref_h[3] += d;
  endfunction

  // Software-side padding into little-endian 32-bit words
  function automatic void pad(input string s);
    byte unsigned bq [$];
    longint unsigned bits;
    for (int i = 0; i < s.len(); i++) bq.push_back(s[i]);
    bq.push_back(8'h80);
    while (bq.size() % 64 != 56) bq.push_back(8'h00);
    bits = 64'(s.len()) * 8;
    for (int i = 0; i < 8; i++) bq.push_back(8'(bits >> (8*i)));
    words.delete();
    for (int w = 0; w < bq.size() / 4; w++)
      words.push_back({bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]});
  endfunction

  function automatic logic [127:0] dig_to_words(input logic [127:0] dg);
    logic [127:0] o;
    for (int j = 0; j < 4; j++) begin
      logic [31:0] w;
      w = dg[127-32*j -: 32];
      o[127-32*j -: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end
    return o;
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = {24'h0, a}; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n <= 50) begin
      @(negedge clk); #1; n++;
    end
    if (n > 50) chk("aw_timeout", 1, 0);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, 0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = {24'h0, a}; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n <= 50) begin
      @(negedge clk); #1; n++;
    end
    if (n > 50) chk("ar_timeout", 1, 0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid", rvalid, 1);
    chk("rresp", rresp, 0);
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic load_msg();
    for (int i = 0; i < 16; i++)
      axi_write(8'(8'h10 + 4*i), cur_msg[i], 4'hf);
  endtask

  task automatic run_block(output logic [127:0] got);
    logic [31:0] d;
    int n;
    axi_write(8'h04, 32'h1, 4'hf);
    n = 0;
    d = 32'h0;
    while (!d[0] && n < 100) begin
      axi_read(8'h00, d);
      n++;
    end
    if (!d[0]) chk("poll_timeout", 1, 0);
    chk("status_done", d, 32'h3);
    for (int j = 0; j < 4; j++) begin
      axi_read(8'(8'h50 + 4*j), d);
      got[127-32*j -: 32] = d;
    end
  endtask

  typedef struct {
    string        msg;
    logic [127:0] dig;
  } vec_t;

  vec_t        vt [3];
  logic [31:0] rd;
  logic [127:0] got, iv_w;
  int          lat;
  int          nblk;

  initial begin
    vt[0] = '{"", 128'hd41d8cd98f00b204e9800998ecf8427e};
    vt[1] = '{"Test vector from febooti.com",
              128'h500ab6613c6db7fbd30c62f5ff573d0f};
    vt[2] = '{"The quick brown fox jumps over the lazy dog",
              128'h9e107d9d372bb6826bd81d3542a419d6};
    iv_w = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    init_tables();

    rst_n = 1'b0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_awready", awready, 0);
    rst_n = 1'b1;

    axi_read(8'h00, rd);
    chk("rst_status", rd, 32'h1);
    for (int j = 0; j < 4; j++) begin
      axi_read(8'(8'h50 + 4*j), rd);
      chk("rst_hash", rd, iv_w[127-32*j -: 32]);
    end
    axi_read(8'h10, rd);
    chk("rst_msg0", rd, 0);

    // Known-answer vectors
    for (int v = 0; v < 3; v++) begin
      axi_write(8'h08, 32'h1, 4'hf);
      pad(vt[v].msg);
      for (int i = 0; i < 16; i++) cur_msg[i] = words[i];
      load_msg();
      run_block(got);
      chk($sformatf("kat%0d", v), got, dig_to_words(vt[v].dig));
    end

    // Two-block message chained through internal state
    axi_write(8'h08, 32'h1, 4'hf);
    pad("aaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa");
    chk("two_blk_words", 32'(words.size()), 32);
    ref_iv();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) cur_msg[i] = words[16*b + i];
      load_msg();
      run_block(got);
      md5_ref();
      chk($sformatf("chain_blk%0d", b), got,
          {ref_h[0], ref_h[1], ref_h[2], ref_h[3]});
    end

    // Random blocks chained against the model
    axi_write(8'h08, 32'h1, 4'hf);
    ref_iv();
    nblk = 3;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 16; i++) cur_msg[i] = $urandom;
      load_msg();
      run_block(got);
      md5_ref();
      chk($sformatf("rand_blk%0d", b), got,
          {ref_h[0], ref_h[1], ref_h[2], ref_h[3]});
    end
    axi_read(8'h60, rd);
`ifdef MD5_BLOCK_COUNT_EN
    chk("blk_cnt", rd, 32'(nblk));
`else
    chk("blk_cnt_off", rd, 0);
`endif

    // Latency, busy CTRL, busy MSG write, reads mid-run
    axi_write(8'h08, 32'h1, 4'hf);
    ref_iv();
    for (int i = 0; i < 16; i++) cur_msg[i] = $urandom;
    load_msg();
    @(negedge clk);
    awaddr = 32'h04; wdata = 32'h1; wstrb = 4'hf;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    chk("ctrl_awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    fork
      begin
        for (int i = 1; i <= 200; i++) begin
          @(posedge clk); #1;
          if (dut.ready) begin lat = i; break; end
        end
      end
      begin
        logic [31:0] d2;
        repeat (8) @(posedge clk);
        axi_read(8'h00, d2);
        chk("busy_status", d2, 0);
        axi_read(8'h50, d2);
        chk("busy_hash0", d2, 32'h67452301);
        axi_write(8'h04, 32'h1, 4'hf);
        axi_write(8'h10, ~cur_msg[0], 4'hf);
        axi_read(8'h00, d2);
        chk("busy_status2", d2, 0);
      end
    join
    chk("latency", lat, 66);
    md5_ref();
    got = '0;
    for (int j = 0; j < 4; j++) begin
      axi_read(8'(8'h50 + 4*j), rd);
      got[127-32*j -: 32] = rd;
    end
    chk("busy_digest", got, {ref_h[0], ref_h[1], ref_h[2], ref_h[3]});
    axi_read(8'h10, rd);
    chk("busy_msg_kept", rd, cur_msg[0]);
    axi_read(8'h00, rd);
    chk("ready_after", rd, 32'h3);

    // Soft reset aborts a running block
    axi_write(8'h04, 32'h1, 4'hf);
    repeat (20) @(posedge clk);
    axi_write(8'h08, 32'h1, 4'hf);
    axi_read(8'h00, rd);
    chk("abort_status", rd, 32'h1);
    for (int j = 0; j < 4; j++) begin
      axi_read(8'(8'h50 + 4*j), rd);
      chk("abort_hash", rd, iv_w[127-32*j -: 32]);
    end

    // Byte strobes and unmapped accesses
    axi_write(8'h10, 32'h11223344, 4'hf);
    axi_write(8'h10, 32'haabbccdd, 4'b0001);
    axi_read(8'h10, rd);
    chk("wstrb_b0", rd, 32'h112233dd);
    axi_write(8'h10, 32'h55667788, 4'b1000);
    axi_read(8'h10, rd);
    chk("wstrb_b3", rd, 32'h552233dd);
    axi_write(8'hfc, 32'hffffffff, 4'hf);
    axi_read(8'hfc, rd);
    chk("unmapped", rd, 0);

    // rdata held while rready is low
    rready = 1'b0;
    @(negedge clk);
    araddr = 32'h10; arvalid = 1'b1;
    #1;
    chk("ar_ready_idle", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, 32'h552233dd);
      chk("hold_arready", arready, 0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    chk("rvalid_drop", rvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
